// File: rtl/alu_arbiter_pkg.sv
// Shared widths, opcodes and FSM encodings for the ALU arbiter slice.
// Consumed by alu_arbiter and rr_pick2.
package alu_arbiter_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int ALU_OPRN_WIDTH   = 6;
    localparam int SETTLE_CNT_WIDTH = 4;

    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h01;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h02;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h03;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHR = 6'h04;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHL = 6'h05;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h06;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h07;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h08;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLT = 6'h09;

    typedef enum logic [1:0] {
        ARB_ST_IDLE  = 2'd0,
        ARB_ST_DRIVE = 2'd1,
        ARB_ST_DONE  = 2'd2
    } arb_state_t;

    function automatic logic oprn_legal(input int unsigned oprn);
        return (oprn >= int'(ALU_OPRN_ADD)) && (oprn <= int'(ALU_OPRN_SLT));
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector; a tie goes to the port
// that did not win last time.
module rr_pick2
    import alu_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant_idx
);

    logic w_both;

    assign w_both        = i_req0 & i_req1;
    assign o_grant_valid = i_req0 | i_req1;
    assign o_grant_idx   = w_both ? ~i_last_grant : i_req1;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional opcode screening at grant: ALU_ARB_OPRN_CHECK_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = alu_arbiter_pkg::DATA_WIDTH,
    parameter int OPRN_WIDTH    = ALU_OPRN_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] op1_0,
    input  logic [DATA_WIDTH-1:0] op2_0,
    input  logic [DATA_WIDTH-1:0] op1_1,
    input  logic [DATA_WIDTH-1:0] op2_1,
    input  logic [OPRN_WIDTH-1:0] oprn_0,
    input  logic [OPRN_WIDTH-1:0] oprn_1,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [OPRN_WIDTH-1:0] alu_oprn,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done0,
    output logic                  done1,
    output logic                  busy,
    output logic                  err
);

    localparam logic [SETTLE_CNT_WIDTH-1:0] LP_CNT_INIT =
        SETTLE_CNT_WIDTH'(SETTLE_CYCLES - 1);

    arb_state_t                  r_state;
    logic [SETTLE_CNT_WIDTH-1:0] r_cnt;
    logic                        r_owner;
    logic                        r_last_grant;
    logic [DATA_WIDTH-1:0]       r_alu_op1;
    logic [DATA_WIDTH-1:0]       r_alu_op2;
    logic [OPRN_WIDTH-1:0]       r_alu_oprn;
    logic [DATA_WIDTH-1:0]       r_result;
    logic                        r_done0;
    logic                        r_done1;
    logic                        r_busy;

    logic                        w_grant_valid;
    logic                        w_grant_idx;
    logic [DATA_WIDTH-1:0]       w_op1;
    logic [DATA_WIDTH-1:0]       w_op2;
    logic [OPRN_WIDTH-1:0]       w_oprn;
    logic                        w_oprn_ok;

    rr_pick2 u_pick (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_grant (r_last_grant),
        .o_grant_valid(w_grant_valid),
        .o_grant_idx  (w_grant_idx)
    );

    assign w_op1  = w_grant_idx ? op1_1  : op1_0;
    assign w_op2  = w_grant_idx ? op2_1  : op2_0;
    assign w_oprn = w_grant_idx ? oprn_1 : oprn_0;

`ifdef ALU_ARB_OPRN_CHECK_EN
    logic r_err;

    assign w_oprn_ok = oprn_legal(32'(w_oprn));
    assign err       = r_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (r_state == ARB_ST_IDLE && w_grant_valid) begin
            r_err <= ~w_oprn_ok;
        end
    end
`else
    assign w_oprn_ok = 1'b1;
    assign err       = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ARB_ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_oprn   <= '0;
            r_result     <= '0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                ARB_ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_busy       <= 1'b1;
                        if (w_oprn_ok) begin
                            r_alu_op1  <= w_op1;
                            r_alu_op2  <= w_op2;
                            r_alu_oprn <= w_oprn;
                            r_cnt      <= LP_CNT_INIT;
                            r_state    <= ARB_ST_DRIVE;
                        end else begin
                            // Rejected opcode never reaches the ALU.
                            r_result <= '0;
                            r_done0  <= ~w_grant_idx;
                            r_done1  <= w_grant_idx;
                            r_state  <= ARB_ST_DONE;
                        end
                    end
                end
                ARB_ST_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_result <= alu_result;
                        r_done0  <= ~r_owner;
                        r_done1  <= r_owner;
                        r_state  <= ARB_ST_DONE;
                    end
                end
                ARB_ST_DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ARB_ST_IDLE;
                end
                default: begin
                    r_state <= ARB_ST_IDLE;
                end
            endcase
        end
    end

    assign alu_op1  = r_alu_op1;
    assign alu_op2  = r_alu_op2;
    assign alu_oprn = r_alu_oprn;
    assign result   = r_result;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign busy     = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (settle 1 and 3), table vectors,
// handshake corner sequences and random traffic against a txn-level model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int S_A = 1;
    localparam int S_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        req0   [2];
    logic        req1   [2];
    logic [31:0] op1_0  [2];
    logic [31:0] op2_0  [2];
    logic [31:0] op1_1  [2];
    logic [31:0] op2_1  [2];
    logic [5:0]  oprn_0 [2];
    logic [5:0]  oprn_1 [2];
    logic [31:0] a_op1  [2];
    logic [31:0] a_op2  [2];
    logic [5:0]  a_oprn [2];
    logic [31:0] a_res  [2];
    logic [31:0] res    [2];
    logic        dn0    [2];
    logic        dn1    [2];
    logic        bsy    [2];
    logic        er     [2];

    int          n_vec = 0;
    int          n_err = 0;
    int          model_last [2];
    logic [31:0] pa [2][2];
    logic [31:0] pb [2][2];
    logic [5:0]  pop [2][2];

    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b,
                                          logic [5:0] op);
        case (op)
            6'h01: return a + b;
            6'h02: return a - b;
            6'h03: return a * b;
            6'h04: return a >> b;
            6'h05: return a << b;
            6'h06: return a & b;
            6'h07: return a | b;
            6'h08: return ~(a | b);
            6'h09: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign a_res[0] = alu_f(a_op1[0], a_op2[0], a_oprn[0]);
    assign a_res[1] = alu_f(a_op1[1], a_op2[1], a_oprn[1]);

    alu_arbiter #(.SETTLE_CYCLES(S_A)) u_a (
        .CLK(clk), .RST(rst[0]), .req0(req0[0]), .req1(req1[0]),
        .op1_0(op1_0[0]), .op2_0(op2_0[0]), .op1_1(op1_1[0]), .op2_1(op2_1[0]),
        .oprn_0(oprn_0[0]), .oprn_1(oprn_1[0]),
        .alu_op1(a_op1[0]), .alu_op2(a_op2[0]), .alu_oprn(a_oprn[0]),
        .alu_result(a_res[0]), .result(res[0]), .done0(dn0[0]), .done1(dn1[0]),
        .busy(bsy[0]), .err(er[0])
    );

    alu_arbiter #(.SETTLE_CYCLES(S_B)) u_b (
        .CLK(clk), .RST(rst[1]), .req0(req0[1]), .req1(req1[1]),
        .op1_0(op1_0[1]), .op2_0(op2_0[1]), .op1_1(op1_1[1]), .op2_1(op2_1[1]),
        .oprn_0(oprn_0[1]), .oprn_1(oprn_1[1]),
        .alu_op1(a_op1[1]), .alu_op2(a_op2[1]), .alu_oprn(a_oprn[1]),
        .alu_result(a_res[1]), .result(res[1]), .done0(dn0[1]), .done1(dn1[1]),
        .busy(bsy[1]), .err(er[1])
    );

    function automatic int settle_of(int inst);
        return (inst == 0) ? S_A : S_B;
    endfunction

    function automatic bit illegal(logic [5:0] op);
        return (op < 6'h01) || (op > 6'h09);
    endfunction

    function automatic int lat(int inst, logic [5:0] op);
`ifdef ALU_ARB_OPRN_CHECK_EN
        if (illegal(op)) return 1;
`endif
        return settle_of(inst) + 1;
    endfunction

    function automatic logic [31:0] exp_r(logic [31:0] a, logic [31:0] b,
                                          logic [5:0] op);
`ifdef ALU_ARB_OPRN_CHECK_EN
        if (illegal(op)) return 32'd0;
`endif
        return alu_f(a, b, op);
    endfunction

    function automatic logic exp_e(logic [5:0] op);
`ifdef ALU_ARB_OPRN_CHECK_EN
        return illegal(op);
`else
        return (op === 6'hxx);
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input int inst, input string nm);
        check({nm, "_op1"},  a_op1[inst], 0);
        check({nm, "_op2"},  a_op2[inst], 0);
        check({nm, "_oprn"}, 32'(a_oprn[inst]), 0);
        check({nm, "_res"},  res[inst], 0);
        check({nm, "_dn0"},  32'(dn0[inst]), 0);
        check({nm, "_dn1"},  32'(dn1[inst]), 0);
        check({nm, "_busy"}, 32'(bsy[inst]), 0);
        check({nm, "_err"},  32'(er[inst]), 0);
    endtask

    task automatic raise(input int inst, input int port, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] op);
        pa[inst][port]  = a;
        pb[inst][port]  = b;
        pop[inst][port] = op;
        if (port == 0) begin
            op1_0[inst] = a; op2_0[inst] = b; oprn_0[inst] = op; req0[inst] = 1'b1;
        end else begin
            op1_1[inst] = a; op2_1[inst] = b; oprn_1[inst] = op; req1[inst] = 1'b1;
        end
    endtask

    // Waits for a done pulse, checks it, then plays the requester's part
    // by dropping req and confirming the pulse lasted one cycle.
    task automatic expect_txn(input int inst, input int port,
                              input logic [31:0] r, input logic e,
                              input int l, input string nm);
        int cyc;
        bit seen;
        int got;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 64) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            seen = dn0[inst] | dn1[inst];
        end
        check({nm, "_done"}, 32'(seen), 1);
        if (!seen) return;
        got = dn1[inst] ? 1 : 0;
        check({nm, "_port"},   got, port);
        check({nm, "_both"},   32'(dn0[inst] & dn1[inst]), 0);
        check({nm, "_result"}, res[inst], r);
        check({nm, "_err"},    32'(er[inst]), 32'(e));
        check({nm, "_lat"},    cyc, l);
        model_last[inst] = port;
        if (dn0[inst]) req0[inst] = 1'b0;
        if (dn1[inst]) req1[inst] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({nm, "_pulse"}, 32'(dn0[inst] | dn1[inst]), 0);
        check({nm, "_hold"},  res[inst], r);
    endtask

    task automatic expect_port(input int inst, input int port, input string nm);
        expect_txn(inst, port,
                   exp_r(pa[inst][port], pb[inst][port], pop[inst][port]),
                   exp_e(pop[inst][port]), lat(inst, pop[inst][port]), nm);
    endtask

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        int          mask;
        int          inst;
        int          saw;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  ro;

        tbl[0] = '{0, 32'd3,        32'd13,     6'h01, 32'd16,        1'b0};
        tbl[1] = '{1, 32'd100,      32'd58,     6'h02, 32'd42,        1'b0};
        tbl[2] = '{0, 32'd6,        32'd7,      6'h03, 32'd42,        1'b0};
        tbl[3] = '{1, 32'd8,        32'd1,      6'h04, 32'd4,         1'b0};
        tbl[4] = '{0, 32'd1,        32'd4,      6'h05, 32'd16,        1'b0};
        tbl[5] = '{1, 32'hF0F0,     32'hFF00,   6'h06, 32'hF000,      1'b0};
        tbl[6] = '{0, 32'hF0,       32'h0F,     6'h07, 32'hFF,        1'b0};
        tbl[7] = '{1, 32'd0,        32'd0,      6'h08, 32'hFFFF_FFFF, 1'b0};
        tbl[8] = '{0, 32'hFFFF_FFFF, 32'd1,     6'h09, 32'd1,         1'b0};
`ifdef ALU_ARB_OPRN_CHECK_EN
        tbl[9] = '{0, 32'd5,        32'd3,      6'h0A, 32'd0,         1'b1};
`else
        tbl[9] = '{0, 32'd5,        32'd3,      6'h0A, 32'd6,         1'b0};
`endif

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req0[i] = 1'b0; req1[i] = 1'b0;
            op1_0[i] = '0; op2_0[i] = '0; op1_1[i] = '0; op2_1[i] = '0;
            oprn_0[i] = '0; oprn_1[i] = '0;
            model_last[i] = 1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero(0, "rst_a");
        check_zero(1, "rst_b");
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // Simultaneous requests straight after reset: port 0 first.
        raise(0, 0, 32'd45, 32'd15, 6'h03 - 6'h02);
        raise(0, 1, 32'd7,  32'd7,  6'h03);
        expect_txn(0, 0, 32'd60, 1'b0, S_A + 1, "tie_p0");
        expect_txn(0, 1, 32'd49, 1'b0, S_A + 1, "tie_p1");

        for (int i = 0; i < 10; i++) begin
            raise(0, tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].op);
            expect_txn(0, tbl[i].port, tbl[i].r, tbl[i].e,
                       lat(0, tbl[i].op), $sformatf("tbl%0d", i));
        end

        // Continuous contention: each owner re-requests at once.
        raise(0, 0, 32'd10, 32'd1, 6'h01);
        raise(0, 1, 32'd20, 32'd2, 6'h02);
        for (int k = 0; k < 4; k++) begin
            first = 1 - model_last[0];
            expect_port(0, first, $sformatf("rr%0d", k));
            if (k < 3) raise(0, first, 32'(k + 30), 32'd3, 6'h01);
        end
        expect_port(0, 1 - model_last[0], "rr_tail");

        // Long settle: operands frozen even if requester changes them.
        raise(1, 1, 32'd8, 32'd1, 6'h04);
        @(negedge clk);
        op1_1[1] = 32'hDEAD; op2_1[1] = 32'd7; oprn_1[1] = 6'h02;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stab_op1_%0d", i),  a_op1[1], 32'd8);
            check($sformatf("stab_op2_%0d", i),  a_op2[1], 32'd1);
            check($sformatf("stab_oprn_%0d", i), 32'(a_oprn[1]), 32'h04);
            check($sformatf("stab_busy_%0d", i), 32'(bsy[1]), 1);
            if (i < 2) @(negedge clk);
        end
        expect_txn(1, 1, 32'd4, 1'b0, 1, "settle3");

        // Reset in the middle of DRIVE aborts silently.
        raise(1, 0, 32'd5, 32'd6, 6'h01);
        @(negedge clk);
        check("pre_rst_busy", 32'(bsy[1]), 1);
        rst[1]  = 1'b1;
        req0[1] = 1'b0;
        @(negedge clk);
        check_zero(1, "mid_rst");
        rst[1] = 1'b0;
        model_last[1] = 1;
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | int'(dn0[1]) | int'(dn1[1]);
        end
        check("rst_nodone", saw, 0);
        raise(1, 0, 32'd1, 32'd2, 6'h05);
        expect_txn(1, 0, 32'd4, 1'b0, S_B + 1, "post_rst");

        for (int it = 0; it < 60; it++) begin
            inst = int'($urandom_range(0, 1));
            mask = int'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                if (mask[p]) begin
                    ro = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(1, 9))
                                                    : 6'($urandom_range(0, 63));
                    ra = $urandom;
                    rb = (ro == 6'h04 || ro == 6'h05) ? 32'($urandom_range(0, 31))
                                                      : $urandom;
                    raise(inst, p, ra, rb, ro);
                end
            end
            if (mask == 3) begin
                first = 1 - model_last[inst];
                expect_port(inst, first, $sformatf("rnd%0d_a", it));
                expect_port(inst, 1 - first, $sformatf("rnd%0d_b", it));
            end else begin
                expect_port(inst, mask - 1, $sformatf("rnd%0d", it));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
